// File: rtl/dot4x_drp_pkg.sv
// Shared types and constants for the dot4x MMCM run-time PAL/NTSC reprogrammer.
// DRP register addresses follow the 7-series MMCM register map.
package dot4x_drp_pkg;

  localparam int NUM_REGS = 11;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int RST_HOLD = 4;

  localparam logic STD_PAL  = 1'b0;
  localparam logic STD_NTSC = 1'b1;

  localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] CLKFBOUT_REG2 = 7'h15;
  localparam logic [6:0] DIVCLK        = 7'h16;
  localparam logic [6:0] LOCK1         = 7'h18;
  localparam logic [6:0] LOCK2         = 7'h19;
  localparam logic [6:0] LOCK3         = 7'h1A;
  localparam logic [6:0] FILT1         = 7'h4E;
  localparam logic [6:0] FILT2         = 7'h4F;
  localparam logic [6:0] POWER         = 7'h28;

  typedef enum logic [3:0] {
    ST_START,
    ST_RST_MMCM,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_NEXT,
    ST_RELEASE,
    ST_LOCK_WAIT,
    ST_IDLE
  } state_t;

endpackage

// File: rtl/dot4x_drp_rom.sv
// Register set for both standards: PAL M=52.875 O=20.125, NTSC M=60 O=22, D=1.
// Mask bits set to 1 are preserved from the read-back value; data only touches cleared mask bits.
module dot4x_drp_rom
  import dot4x_drp_pkg::*;
(
  input  logic             std_sel,
  input  logic [IDX_W-1:0] idx,
  output logic [6:0]       addr,
  output logic [15:0]      mask,
  output logic [15:0]      data
);

  logic ntsc;
  assign ntsc = (std_sel == STD_NTSC);

  // Fractional fields: PAL CLKOUT0 frac=1/8, CLKFBOUT frac=7/8, both with FRAC_EN set.
  always_comb begin
    addr = 7'h00;
    mask = 16'hFFFF;
    data = 16'h0000;
    case (idx)
      4'd0:  begin addr = CLKOUT0_REG1;  mask = 16'h1000; data = ntsc ? 16'h02CB : 16'h028A; end
      4'd1:  begin addr = CLKOUT0_REG2;  mask = 16'h8000; data = ntsc ? 16'h0000 : 16'h1800; end
      4'd2:  begin addr = CLKFBOUT_REG1; mask = 16'h1000; data = ntsc ? 16'h079E : 16'h069A; end
      4'd3:  begin addr = CLKFBOUT_REG2; mask = 16'h8000; data = ntsc ? 16'h0000 : 16'h7800; end
      4'd4:  begin addr = DIVCLK;        mask = 16'hC000; data = 16'h1041; end
      4'd5:  begin addr = LOCK1;         mask = 16'hFC00; data = 16'h03E8; end
      4'd6:  begin addr = LOCK2;         mask = 16'h8000; data = ntsc ? 16'h1C01 : 16'h1801; end
      4'd7:  begin addr = LOCK3;         mask = 16'h8000; data = ntsc ? 16'h1FE9 : 16'h1BE9; end
      4'd8:  begin addr = FILT1;         mask = 16'h66FF; data = ntsc ? 16'h1800 : 16'h0900; end
      4'd9:  begin addr = FILT2;         mask = 16'h666F; data = ntsc ? 16'h9010 : 16'h1190; end
      4'd10: begin addr = POWER;         mask = 16'h0000; data = 16'hFFFF; end
      default: ;
    endcase
  end

endmodule

// File: rtl/dot4x_drp_std_switch.sv
// Run-time PAL/NTSC switch for the dot4x MMCM: holds it in reset, read-modify-writes
// the ROM register set over DRP, releases reset and waits for LOCKED.
module dot4x_drp_std_switch
  import dot4x_drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in12mhz,
  input  logic        reset,
  input  logic        std_sel,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] do_in,
  input  logic        drdy,
  output logic        mmcm_rst,
  input  logic        locked,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        active_std
);

  localparam int TIMER_W = $clog2(LOCK_TIMEOUT + 2);
  localparam logic [TIMER_W-1:0] DRDY_LIMIT = TIMER_W'(DRDY_TIMEOUT);
  localparam logic [TIMER_W-1:0] LOCK_LIMIT = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [1:0]         RST_LAST   = 2'(RST_HOLD - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               target;
  logic [1:0]         rst_cnt;
  logic [TIMER_W-1:0] timer;
  logic [15:0]        rd_data;
  logic               drp_err;
  logic [6:0]         rom_addr;
  logic [15:0]        rom_mask;
  logic [15:0]        rom_data;

  dot4x_drp_rom u_rom (
    .std_sel (target),
    .idx     (idx),
    .addr    (rom_addr),
    .mask    (rom_mask),
    .data    (rom_data)
  );

  always_ff @(posedge clk_in12mhz) begin
    if (reset) state <= ST_START;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_START:     state_next = ST_RST_MMCM;
      ST_RST_MMCM:  if (rst_cnt == RST_LAST) state_next = ST_RD;
      ST_RD:        state_next = ST_RD_WAIT;
      ST_RD_WAIT:   if (drdy) state_next = ST_WR;
                    else if (timer > DRDY_LIMIT) state_next = ST_RELEASE;
      ST_WR:        state_next = ST_WR_WAIT;
      ST_WR_WAIT:   if (drdy) state_next = ST_NEXT;
                    else if (timer > DRDY_LIMIT) state_next = ST_RELEASE;
      ST_NEXT:      state_next = (idx == LAST_IDX) ? ST_RELEASE : ST_RD;
      ST_RELEASE:   state_next = ST_LOCK_WAIT;
      ST_LOCK_WAIT: if (locked || (timer > LOCK_LIMIT)) state_next = ST_IDLE;
      ST_IDLE:      if (std_sel != active_std) state_next = ST_START;
      default:      state_next = ST_START;
    endcase
  end

  // DRP strobes are decoded from state so a reset mid-transaction drops den immediately.
  always_comb begin
    daddr    = 7'h00;
    den      = 1'b0;
    dwe      = 1'b0;
    di       = 16'h0000;
    mmcm_rst = 1'b1;
    busy     = 1'b1;
    case (state)
      ST_RD: begin
        daddr = rom_addr;
        den   = 1'b1;
      end
      ST_WR: begin
        daddr = rom_addr;
        den   = 1'b1;
        dwe   = 1'b1;
        di    = (rd_data & rom_mask) | rom_data;
      end
      ST_RELEASE, ST_LOCK_WAIT: mmcm_rst = 1'b0;
      ST_IDLE: begin
        mmcm_rst = 1'b0;
        busy     = 1'b0;
      end
      default: ;
    endcase
  end

  // One shared saturating timer serves both the drdy and the lock timeouts.
  always_ff @(posedge clk_in12mhz) begin
    if (reset) begin
      idx        <= '0;
      target     <= STD_PAL;
      rst_cnt    <= '0;
      timer      <= '0;
      rd_data    <= '0;
      drp_err    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      active_std <= STD_PAL;
    end else begin
      done <= 1'b0;
      case (state)
        ST_START: begin
          target  <= std_sel;
          idx     <= '0;
          rst_cnt <= '0;
          drp_err <= 1'b0;
        end
        ST_RST_MMCM: rst_cnt <= rst_cnt + 2'd1;
        ST_RD, ST_WR, ST_RELEASE: timer <= '0;
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (drdy) begin
            if (state == ST_RD_WAIT) rd_data <= do_in;
          end else if (timer > DRDY_LIMIT) begin
            error   <= 1'b1;
            drp_err <= 1'b1;
          end else if (!(&timer)) begin
            timer <= timer + 1'b1;
          end
        end
        ST_NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
        ST_LOCK_WAIT: begin
          if (locked) begin
            active_std <= target;
            done       <= 1'b1;
            error      <= drp_err;
          end else if (timer > LOCK_LIMIT) begin
            active_std <= target;
            error      <= 1'b1;
          end else if (!(&timer)) begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
